// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the C_bus ALU driver:
//   - opcode encodings OP_ADD..OP_MUL (3 bits)
//   - FSM state encoding (IDLE=0, MUL_RUN=1, DONE=2)
//   - default datapath / register-file dimensions
// Optional feature macro used by the files that import this package:
//   ALU_SATURATE_EN  - saturating ADD/SUB/INC/MUL instead of modulo wrap.
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W_DEFAULT   = 16;
    localparam int NUM_REGS_DEFAULT = 8;
    localparam int SEL_W_DEFAULT    = 4;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_PASSA = 3'd2;
    localparam logic [2:0] OP_PASSB = 3'd3;
    localparam logic [2:0] OP_INC   = 3'd4;
    localparam logic [2:0] OP_SHR   = 3'd5;
    localparam logic [2:0] OP_SHL   = 3'd6;
    localparam logic [2:0] OP_MUL   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/alu_cbus_driver_if.sv
// ----------------------------------------------------------------------------
// alu_cbus_driver_if
// Bundles the microinstruction inputs and the C_bus/load outputs of the ALU.
//   master modport (sequencer / testbench): drives start, op, a_bus, b_bus,
//     dest_sel; observes C_bus, load_vec, busy, done, z_flag, dbg_state.
//   slave modport (alu_cbus_driver): the reverse.
// Handshake: a microinstruction is accepted on a rising edge where start=1
// and the ALU is idle (busy=0, done=0); start in any other cycle is dropped,
// nothing is queued. Every accepted op produces exactly one done pulse, and
// C_bus/z_flag/load_vec are valid in that same cycle.
// dbg_state exposes the FSM state for observation only.
// ----------------------------------------------------------------------------
interface alu_cbus_driver_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 4
);
    import alu_pkg::*;

    logic                start;
    logic [2:0]          op;
    logic [DATA_W-1:0]   a_bus;
    logic [DATA_W-1:0]   b_bus;
    logic [SEL_W-1:0]    dest_sel;
    logic [DATA_W-1:0]   C_bus;
    logic [NUM_REGS-1:0] load_vec;
    logic                busy;
    logic                done;
    logic                z_flag;
    state_t              dbg_state;

    modport master (
        output start, op, a_bus, b_bus, dest_sel,
        input  C_bus, load_vec, busy, done, z_flag, dbg_state
    );

    modport slave (
        input  start, op, a_bus, b_bus, dest_sel,
        output C_bus, load_vec, busy, done, z_flag, dbg_state
    );

endinterface

// File: rtl/alu_cbus_driver_seq_mul.sv
// ----------------------------------------------------------------------------
// seq_mul
// Iterative shift-add multiplier, one partial product per clock.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   go          1-cycle launch; a/b are sampled on this edge
//   a, b        DATA_W-bit unsigned operands
//   busy        high while iterations remain
//   product     PROD_W-bit accumulator (DATA_W for modulo, 2*DATA_W when the
//               caller needs the upper half, e.g. for ALU_SATURATE_EN)
// The launch edge already folds in multiplier bit 0 straight from the input
// operands, so the remaining DATA_W-1 bits take DATA_W-1 busy cycles and the
// product is final in the first cycle busy is low.
// ----------------------------------------------------------------------------
module seq_mul #(
    parameter int DATA_W = 16,
    parameter int PROD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic [PROD_W-1:0] product
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic [PROD_W-1:0] mcand_q, mcand_d;
    logic [PROD_W-1:0] acc_q,   acc_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              busy_q,  busy_d;

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (go) begin
            acc_d    = b[0] ? PROD_W'(a) : '0;
            mcand_d  = PROD_W'(a) << 1;
            mplier_d = b >> 1;
            cnt_d    = CNT_W'(DATA_W - 1);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_W'(1);
            busy_d   = (cnt_q != CNT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign product = acc_q;

endmodule

// File: rtl/alu_cbus_driver.sv
// ----------------------------------------------------------------------------
// alu_cbus_driver
// Datapath ALU feeding the general purpose register file over C_bus.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears all outputs and the FSM
//   bus    alu_cbus_driver_if.slave:
//            start/op/a_bus/b_bus/dest_sel in; C_bus (registered result),
//            load_vec (one-hot, DONE cycle only), busy (multiply running),
//            done (1-cycle), z_flag, dbg_state out
// Single-cycle ops register their result on the accepting edge; MUL hands
// the operands to seq_mul and the result is registered 16 cycles later.
// Either way the FSM then spends one cycle in DONE, which is the only cycle
// load_vec and done are high, and always returns to IDLE afterwards.
// Build option: ALU_SATURATE_EN makes ADD/INC/MUL clamp to all-ones on
// overflow and SUB clamp to zero on borrow; otherwise all ops wrap.
// ----------------------------------------------------------------------------
module alu_cbus_driver
    import alu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int NUM_REGS = NUM_REGS_DEFAULT,
    parameter int SEL_W    = SEL_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_cbus_driver_if.slave   bus
);

`ifdef ALU_SATURATE_EN
    // Saturation must see the full product to detect upper-half overflow.
    localparam int PROD_W = 2 * DATA_W;
`else
    localparam int PROD_W = DATA_W;
`endif

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                z_q, z_d;
    logic [SEL_W-1:0]    dest_q, dest_d;
    logic [DATA_W-1:0]   alu_res;
    logic [DATA_W-1:0]   mul_res;
    logic [NUM_REGS-1:0] load_vec;
    logic                mul_go;
    logic                mul_busy;
    logic [PROD_W-1:0]   mul_prod;

    seq_mul #(
        .DATA_W (DATA_W),
        .PROD_W (PROD_W)
    ) u_seq_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .go      (mul_go),
        .a       (bus.a_bus),
        .b       (bus.b_bus),
        .busy    (mul_busy),
        .product (mul_prod)
    );

`ifdef ALU_SATURATE_EN
    // One extra bit on each single-cycle result carries the carry/borrow.
    logic [DATA_W:0] sum_ext, diff_ext, inc_ext;
    assign sum_ext  = {1'b0, bus.a_bus} + {1'b0, bus.b_bus};
    assign diff_ext = {1'b0, bus.a_bus} - {1'b0, bus.b_bus};
    assign inc_ext  = {1'b0, bus.a_bus} + (DATA_W + 1)'(1);
`endif

    // Single-cycle operations; MUL is handled by seq_mul.
    always_comb begin
        alu_res = '0;
        case (bus.op)
`ifdef ALU_SATURATE_EN
            OP_ADD: alu_res = sum_ext[DATA_W]  ? '1 : sum_ext[DATA_W-1:0];
            OP_SUB: alu_res = diff_ext[DATA_W] ? '0 : diff_ext[DATA_W-1:0];
            OP_INC: alu_res = inc_ext[DATA_W]  ? '1 : inc_ext[DATA_W-1:0];
`else
            OP_ADD: alu_res = bus.a_bus + bus.b_bus;
            OP_SUB: alu_res = bus.a_bus - bus.b_bus;
            OP_INC: alu_res = bus.a_bus + DATA_W'(1);
`endif
            OP_PASSA: alu_res = bus.a_bus;
            OP_PASSB: alu_res = bus.b_bus;
            OP_SHR:   alu_res = bus.a_bus >> bus.b_bus[3:0];
            OP_SHL:   alu_res = bus.a_bus << bus.b_bus[3:0];
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
`ifdef ALU_SATURATE_EN
        mul_res = (|mul_prod[PROD_W-1:DATA_W]) ? '1 : mul_prod[DATA_W-1:0];
`else
        mul_res = mul_prod;
`endif
    end

    // Next-state / result logic. Inputs are only looked at in IDLE, so start,
    // op, operands and dest_sel are don't-care during MUL_RUN and DONE.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        z_d      = z_q;
        dest_d   = dest_q;
        mul_go   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    dest_d = bus.dest_sel;
                    if (bus.op == OP_MUL) begin
                        mul_go  = 1'b1;
                        state_d = ST_MUL_RUN;
                    end else begin
                        result_d = alu_res;
                        z_d      = (alu_res == '0);
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_MUL_RUN: begin
                // seq_mul's product is final in its first non-busy cycle,
                // which is the 16th cycle spent here.
                if (!mul_busy) begin
                    result_d = mul_res;
                    z_d      = (mul_res == '0);
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            z_q      <= 1'b0;
            dest_q   <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            z_q      <= z_d;
            dest_q   <= dest_d;
        end
    end

    // Out-of-range destinations simply match no bit.
    always_comb begin
        load_vec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            load_vec[i] = (state_q == ST_DONE) && (dest_q == SEL_W'(i));
        end
    end

    assign bus.C_bus     = result_q;
    assign bus.z_flag    = z_q;
    assign bus.load_vec  = load_vec;
    assign bus.busy      = (state_q == ST_MUL_RUN);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_alu_cbus_driver.sv
// ----------------------------------------------------------------------------
// tb_alu_cbus_driver
// Bench for alu_cbus_driver: reset values, a table of single-cycle ops,
// multiply timing, start while busy / in DONE, reset mid-multiply and random
// traffic. Expected results are queued when an op is issued and compared
// when done pulses. Honours ALU_SATURATE_EN for the expected values.
// ----------------------------------------------------------------------------
module tb_alu_cbus_driver;
    import alu_pkg::*;

`ifdef ALU_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  dest;
        logic [15:0] exp_wrap;
        logic [15:0] exp_sat;
    } vec_t;

    logic clk;
    logic rst_n;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   done_cnt = 0;
    logic [24:0] exp_q[$];   // {load_vec[7:0], z, C_bus[15:0]}
    vec_t vecs[14];

    alu_cbus_driver_if bus ();

    alu_cbus_driver dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [24:0] pack_exp(input logic [15:0] c, input logic [3:0] d);
        logic [7:0] ld;
        ld = '0;
        if (d < 4'd8) ld[d[2:0]] = 1'b1;
        return {ld, (c == 16'h0000), c};
    endfunction

    function automatic logic [15:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] w;
        logic [15:0] r;
        r = '0;
        case (op)
            3'd0: begin w = 32'(a) + 32'(b); r = (SAT && w > 32'hFFFF) ? 16'hFFFF : w[15:0]; end
            3'd1: begin r = a - b; if (SAT && b > a) r = 16'h0000; end
            3'd2: r = a;
            3'd3: r = b;
            3'd4: begin w = 32'(a) + 32'd1; r = (SAT && w > 32'hFFFF) ? 16'hFFFF : w[15:0]; end
            3'd5: begin r = a; for (int i = 0; i < int'(b[3:0]); i++) r = {1'b0, r[15:1]}; end
            3'd6: begin r = a; for (int i = 0; i < int'(b[3:0]); i++) r = {r[14:0], 1'b0}; end
            default: begin w = 32'(a) * 32'(b); r = (SAT && w > 32'hFFFF) ? 16'hFFFF : w[15:0]; end
        endcase
        return r;
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input logic [2:0] o, input logic [15:0] av, input logic [15:0] bv,
                         input logic [3:0] d, input logic [15:0] exp_c, input bit do_push);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = o;
        bus.a_bus    = av;
        bus.b_bus    = bv;
        bus.dest_sel = d;
        if (do_push) exp_q.push_back(pack_exp(exp_c, d));
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(negedge clk);
            #1;
            i++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [24:0] e;
        if (rst_n && bus.done) begin
            done_cnt++;
            check("done_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("c_bus",    32'(bus.C_bus),    32'(e[15:0]));
                check("z_flag",   32'(bus.z_flag),   32'(e[16]));
                check("load_vec", 32'(bus.load_vec), 32'(e[24:17]));
                check("busy_at_done", 32'(bus.busy), 32'd0);
            end
        end
    end

    // ---------------- test ----------------
    initial begin
        int d0;
        int busy_cycles;
        logic [2:0]  rop;
        logic [15:0] ra, rb;
        logic [3:0]  rd;

        vecs[0]  = '{OP_ADD,   16'h0003, 16'h0004, 4'd2,  16'h0007, 16'h0007};
        vecs[1]  = '{OP_ADD,   16'hFFFF, 16'h0001, 4'd0,  16'h0000, 16'hFFFF};
        vecs[2]  = '{OP_SUB,   16'h0005, 16'h0007, 4'd1,  16'hFFFE, 16'h0000};
        vecs[3]  = '{OP_SUB,   16'h0009, 16'h0004, 4'd3,  16'h0005, 16'h0005};
        vecs[4]  = '{OP_PASSA, 16'hABCD, 16'h1234, 4'd9,  16'hABCD, 16'hABCD};
        vecs[5]  = '{OP_PASSB, 16'h1111, 16'hBEEF, 4'd4,  16'hBEEF, 16'hBEEF};
        vecs[6]  = '{OP_INC,   16'hFFFF, 16'h0000, 4'd6,  16'h0000, 16'hFFFF};
        vecs[7]  = '{OP_INC,   16'h0041, 16'h0000, 4'd7,  16'h0042, 16'h0042};
        vecs[8]  = '{OP_SHR,   16'h8001, 16'h0003, 4'd2,  16'h1000, 16'h1000};
        vecs[9]  = '{OP_SHL,   16'h00F0, 16'h0014, 4'd1,  16'h0F00, 16'h0F00};
        vecs[10] = '{OP_SHR,   16'h8000, 16'h000F, 4'd5,  16'h0001, 16'h0001};
        vecs[11] = '{OP_SHL,   16'h0001, 16'h0000, 4'd15, 16'h0001, 16'h0001};
        vecs[12] = '{OP_PASSA, 16'h0000, 16'hFFFF, 4'd0,  16'h0000, 16'h0000};
        vecs[13] = '{OP_ADD,   16'h8000, 16'h8000, 4'd5,  16'h0000, 16'hFFFF};

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.op       = 3'd0;
        bus.a_bus    = '0;
        bus.b_bus    = '0;
        bus.dest_sel = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_c_bus",    32'(bus.C_bus),     32'd0);
        check("rst_load_vec", 32'(bus.load_vec),  32'd0);
        check("rst_busy",     32'(bus.busy),      32'd0);
        check("rst_done",     32'(bus.done),      32'd0);
        check("rst_z_flag",   32'(bus.z_flag),    32'd0);
        check("rst_state",    32'(bus.dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        // Table of single-cycle ops: result in the cycle after the accepting
        // edge, then load/done drop while C_bus holds.
        for (int i = 0; i < 14; i++) begin
            logic [15:0] ec;
            ec = SAT ? vecs[i].exp_sat : vecs[i].exp_wrap;
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest, ec, 1'b1);
            @(negedge clk);
            #1;
            check("latency1_drained", 32'(exp_q.size()), 32'd0);
            @(negedge clk);
            #1;
            check("post_done",     32'(bus.done),     32'd0);
            check("post_load_vec", 32'(bus.load_vec), 32'd0);
            check("post_c_hold",   32'(bus.C_bus),    32'(ec));
        end

        // Multiply timing: busy for exactly 16 cycles, result in t+17.
        issue(OP_MUL, 16'h0012, 16'h0010, 4'd5, 16'h0120, 1'b1);
        busy_cycles = 0;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
            if (bus.busy) busy_cycles++;
        end
        check("mul_busy_cycles", 32'(busy_cycles), 32'd16);
        wait_drain(5);

        // Start held through DONE: the second edge is ignored.
        d0 = done_cnt;
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_ADD; bus.a_bus = 16'h0002; bus.b_bus = 16'h0003; bus.dest_sel = 4'd0;
        exp_q.push_back(pack_exp(16'h0005, 4'd0));
        @(posedge clk);
        #1 bus.op = OP_SUB; bus.a_bus = 16'h0009; bus.b_bus = 16'h0001; bus.dest_sel = 4'd1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_drain(10);
        repeat (3) @(negedge clk);
        #1;
        check("done_start_ignored", 32'(done_cnt - d0), 32'd1);
        check("done_start_c_hold",  32'(bus.C_bus),     32'h0005);

        // Start while busy: ADD at t+5 of a MUL is dropped.
        d0 = done_cnt;
        issue(OP_MUL, 16'h0003, 16'h0005, 4'd1, model(OP_MUL, 16'h0003, 16'h0005), 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_ADD; bus.a_bus = 16'h0001; bus.b_bus = 16'h0001; bus.dest_sel = 4'd0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_drain(40);
        repeat (4) @(negedge clk);
        #1;
        check("busy_start_one_done", 32'(done_cnt - d0), 32'd1);

        // Reset at t+8 of a multiply clears outputs immediately.
        issue(OP_MUL, 16'h1234, 16'h0005, 4'd3, 16'h0000, 1'b0);
        repeat (8) @(posedge clk);
        #2;
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_c_bus",    32'(bus.C_bus),     32'd0);
        check("midrst_busy",     32'(bus.busy),      32'd0);
        check("midrst_load_vec", 32'(bus.load_vec),  32'd0);
        check("midrst_done",     32'(bus.done),      32'd0);
        check("midrst_state",    32'(bus.dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(OP_SHR, 16'h8001, 16'h0003, 4'd2, 16'h1000, 1'b1);
        wait_drain(10);

        // Random traffic, all opcodes including MUL.
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 16'($urandom_range(0, 65535));
            rb  = (i % 3 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom_range(0, 65535));
            rd  = 4'($urandom_range(0, 11));
            issue(rop, ra, rb, rd, model(rop, ra, rb), 1'b1);
            wait_drain(40);
        end

        repeat (4) @(negedge clk);
        #1;
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_idle",        32'(bus.dbg_state), 32'(ST_IDLE));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
